game_flow_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 15 +
 rtl/game_flow_ctrl_flap_sync.sv | 27 ++
 rtl/game_flow_ctrl.sv | 146 ++++++++++++++
 tb/tb_game_flow_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the flappy-bird game datapath.
package game_pkg;

  // Codes 0..2 are shared with the bird block's own state encoding.
  typedef enum logic [1:0] {
    NEW_GAME  = 2'd0,
    PLAY      = 2'd1,
    GAME_OVER = 2'd2,
    RESTART   = 2'd3
  } game_state_t;

  localparam int unsigned FLOOR_Y        = 32'd416;
  localparam int unsigned BIRD_Y_INITIAL = 32'd250;

endpackage

// File: rtl/game_flow_ctrl_flap_sync.sv
// Flap button synchronizer followed by a rising-edge detector.
module flap_sync #(
  parameter int SYNC_STAGES = 2  // must be at least 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the raw button through the synchronizer and remember the last synced level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: NEW_GAME/PLAY/GAME_OVER flow, frame-aligned flap, score and high score.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int HOLD_FRAMES = 120,
  parameter int SCORE_W     = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_flap,
  input  logic               frame_tick,
  input  logic               collision,
  input  logic               ground_hit,
  input  logic               pipe_passed,
  output logic               up,
  output logic               game_rst,
  output logic [1:0]         state,
  output logic               pipes_en,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               hold_done
);

  localparam int CNT_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  game_state_t        r_state;
  game_state_t        w_next_state;
  logic               r_pipes_en;
  logic               r_flap_pending;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_high_score;
  logic               w_flap_edge;
  logic               w_hit;
  logic               w_up;
  logic               w_game_rst;
  logic               w_hold_done;
  logic               w_enter_over;

  flap_sync #(.SYNC_STAGES(SYNC_STAGES)) u_flap_sync (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_flap),
    .o_edge (w_flap_edge)
  );

  assign w_hit        = collision | ground_hit;
  assign w_enter_over = (r_state == PLAY) & w_hit;

  // State register; pipe enable is registered alongside so it tracks PLAY exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= NEW_GAME;
      r_pipes_en <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_pipes_en <= (w_next_state == PLAY);
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = NEW_GAME;
    case (r_state)
      NEW_GAME:  if (w_up) w_next_state = PLAY;      else w_next_state = NEW_GAME;
      PLAY:      if (w_hit) w_next_state = GAME_OVER; else w_next_state = PLAY;
      GAME_OVER: if (w_hold_done && frame_tick && r_flap_pending) w_next_state = RESTART;
                 else w_next_state = GAME_OVER;
      RESTART:   w_next_state = NEW_GAME;
      default:   w_next_state = NEW_GAME;
    endcase
  end

  // Output decode from registered state, pending flag and hold counter.
  always_comb begin
    w_up        = frame_tick & r_flap_pending & (r_state != GAME_OVER);
    w_game_rst  = (r_state == RESTART);
    w_hold_done = (r_state == GAME_OVER) && (r_hold_cnt == '0);
  end

  // Flap pending: an edge wins over the frame clear so it survives into the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flap_pending <= 1'b0;
    end else if (w_enter_over) begin
      r_flap_pending <= 1'b0;
    end else if (w_flap_edge) begin
      r_flap_pending <= 1'b1;
    end else if (frame_tick) begin
      r_flap_pending <= 1'b0;
    end else begin
      r_flap_pending <= r_flap_pending;
    end
  end

  // Game-over hold counter, loaded on the hit and counted down per frame to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_cnt <= '0;
    end else if (w_enter_over) begin
      r_hold_cnt <= HOLD_LOAD;
    end else if ((r_state == GAME_OVER) && frame_tick && (r_hold_cnt != '0)) begin
      r_hold_cnt <= r_hold_cnt - CNT_ONE;
    end else begin
      r_hold_cnt <= r_hold_cnt;
    end
  end

  // Score counter; a hit in the same cycle as a pipe pass suppresses the increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_score <= '0;
    end else if (r_state == RESTART) begin
      r_score <= '0;
    end else if ((r_state == PLAY) && pipe_passed && !w_hit && (r_score != SCORE_MAX)) begin
      r_score <= r_score + SCORE_ONE;
    end else begin
      r_score <= r_score;
    end
  end

  // High score captured when a game ends; only a hard reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_high_score <= '0;
    end else if (w_enter_over && (r_score > r_high_score)) begin
      r_high_score <= r_score;
    end else begin
      r_high_score <= r_high_score;
    end
  end

  assign up         = w_up;
  assign game_rst   = w_game_rst;
  assign state      = r_state;
  assign pipes_en   = r_pipes_en;
  assign score      = r_score;
  assign high_score = r_high_score;
  assign hold_done  = w_hold_done;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a short hold period and a 3-bit score.
module tb_game_flow_ctrl;

  localparam int HOLD = 4;
  localparam int SW   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_flap;
  logic          frame_tick;
  logic          collision;
  logic          ground_hit;
  logic          pipe_passed;
  logic          up;
  logic          game_rst;
  logic [1:0]    state;
  logic          pipes_en;
  logic [SW-1:0] score;
  logic [SW-1:0] high_score;
  logic          hold_done;

  int   n_checks = 0;
  int   n_errors = 0;
  logic up_seen;

  always #5 clk = ~clk;

  game_flow_ctrl #(.HOLD_FRAMES(HOLD), .SCORE_W(SW), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_flap    (btn_flap),
    .frame_tick  (frame_tick),
    .collision   (collision),
    .ground_hit  (ground_hit),
    .pipe_passed (pipe_passed),
    .up          (up),
    .game_rst    (game_rst),
    .state       (state),
    .pipes_en    (pipes_en),
    .score       (score),
    .high_score  (high_score),
    .hold_done   (hold_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Button press long enough for the synchronizer to register one edge.
  task automatic flap();
    btn_flap = 1'b1;
    step(1);
    btn_flap = 1'b0;
    step(4);
  endtask

  task automatic frame(output logic up_o);
    frame_tick = 1'b1;
    #1;
    up_o = up;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic pipes(input int n);
    repeat (n) begin
      pipe_passed = 1'b1;
      step(1);
      pipe_passed = 1'b0;
      step(1);
    end
  endtask

  task automatic crash();
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    step(1);
  endtask

  // Burn the hold, then flap and tick into RESTART.
  task automatic finish_hold();
    repeat (HOLD) frame(up_seen);
    flap();
    frame(up_seen);
  endtask

  initial begin
    reset = 1'b1; btn_flap = 1'b0; frame_tick = 1'b0;
    collision = 1'b0; ground_hit = 1'b0; pipe_passed = 1'b0;
    step(2);
    check("rst_state", state, 0);
    check("rst_score", score, 0);
    check("rst_high", high_score, 0);
    check("rst_up", up, 0);
    check("rst_game_rst", game_rst, 0);
    check("rst_pipes_en", pipes_en, 0);
    check("rst_hold_done", hold_done, 0);
    reset = 1'b0;

    step(3);
    frame(up_seen);
    check("idle_tick_up", up_seen, 0);
    check("idle_tick_state", state, 0);
    step(3);
    flap();
    step(35);
    frame(up_seen);
    check("start_up", up_seen, 1);
    check("start_state", state, 1);
    check("start_pipes_en", pipes_en, 1);

    flap(); flap(); flap();
    frame(up_seen);
    check("multi_edge_up", up_seen, 1);
    step(3);
    frame(up_seen);
    check("multi_edge_single", up_seen, 0);

    // Edge pulse lands exactly in the tick cycle.
    btn_flap = 1'b1;
    step(1);
    btn_flap = 1'b0;
    step(1);
    frame(up_seen);
    check("edge_at_tick_up", up_seen, 0);
    step(3);
    frame(up_seen);
    check("edge_next_tick_up", up_seen, 1);
    check("still_play", state, 1);

    pipes(5);
    check("score5", score, 5);
    collision = 1'b1; pipe_passed = 1'b1;
    step(1);
    collision = 1'b0; pipe_passed = 1'b0;
    check("over_state", state, 2);
    check("over_score", score, 5);
    check("over_high", high_score, 5);
    check("over_pipes_en", pipes_en, 0);
    check("over_hold_done", hold_done, 0);
    pipes(1);
    check("pipe_in_over", score, 5);

    flap();
    frame(up_seen);
    check("over_up_forced", up_seen, 0);
    check("hold1_done", hold_done, 0);
    frame(up_seen);
    frame(up_seen);
    check("hold3_done", hold_done, 0);
    check("hold3_state", state, 2);
    flap();
    frame(up_seen);
    check("early_flap_up", up_seen, 0);
    check("early_flap_state", state, 2);
    check("hold4_done", hold_done, 1);
    flap();
    frame(up_seen);
    check("restart_up", up_seen, 0);
    check("restart_state", state, 3);
    check("restart_game_rst", game_rst, 1);
    step(1);
    check("new_state", state, 0);
    check("new_game_rst", game_rst, 0);
    check("new_score", score, 0);
    check("new_high", high_score, 5);
    check("new_hold_done", hold_done, 0);

    flap();
    frame(up_seen);
    check("g2_up", up_seen, 1);
    pipes(9);
    check("sat_score", score, 7);
    ground_hit = 1'b1;
    step(1);
    ground_hit = 1'b0;
    check("ground_state", state, 2);
    check("sat_high", high_score, 7);
    finish_hold();
    step(1);
    check("g3_new", state, 0);
    flap();
    frame(up_seen);
    pipes(2);
    check("g3_score", score, 2);
    crash();
    check("g3_high", high_score, 7);
    check("g3_score_kept", score, 2);

    finish_hold();
    step(1);
    flap();
    frame(up_seen);
    pipes(3);
    check("g4_score", score, 3);
    check("g4_state", state, 1);
    frame_tick = 1'b1;
    reset = 1'b1;
    #2;
    check("arst_state", state, 0);
    check("arst_score", score, 0);
    check("arst_high", high_score, 0);
    check("arst_pipes_en", pipes_en, 0);
    check("arst_game_rst", game_rst, 0);
    check("arst_hold_done", hold_done, 0);
    check("arst_up", up, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
